// File: rtl/dual_grant_req_agent.sv
// dual_grant_req_agent: four independent request/transfer clients driven by a dual-grant arbiter.
// Optional starvation watchdog enabled by defining STARVE_WD_EN.
module dual_grant_req_agent #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_id,
  input  logic [3:0] cmd_len,
  output logic       cmd_ready,
  input  logic [3:0] grant,
  output logic [3:0] req,
  output logic [3:0] beat,
  output logic [3:0] done,
  output logic       err
`ifdef STARVE_WD_EN
  ,
  output logic [3:0] starve
`endif
);
  if (WAIT_LIMIT < 1 || WAIT_LIMIT > 255) begin : g_bad_limit
    $error("WAIT_LIMIT must be 1..255");
  end
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER} state_t;
  state_t     st  [4];
  logic [3:0] len [4];
  logic [4:0] cnt [4];
  logic [3:0] active;
  logic [3:0] accept;
  logic [3:0] last;
  // per-client decode: busy, command acceptance and final-beat detection
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      active[i] = st[i] != ST_IDLE;
      accept[i] = cmd_valid && cmd_id == 2'(i) && !active[i];
      last[i]   = cnt[i] == {1'b0, len[i]};
    end
  end
  assign cmd_ready = !active[cmd_id];
  assign beat      = active & grant;
  // client FSMs, beat counting, done pulses and protocol-error detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        st[i]  <= ST_IDLE;
        len[i] <= 4'd0;
        cnt[i] <= 5'd0;
      end
      req  <= 4'd0;
      done <= 4'd0;
      err  <= 1'b0;
    end else begin
      err <= |(grant & ~active) || ($countones(grant) > 2);
      for (int i = 0; i < 4; i++) begin
        done[i] <= beat[i] && last[i];
        if (accept[i]) begin
          st[i]  <= ST_REQ;
          len[i] <= cmd_len;
          cnt[i] <= 5'd0;
          req[i] <= 1'b1;
        end else if (beat[i]) begin
          cnt[i] <= cnt[i] + 5'd1;
          st[i]  <= last[i] ? ST_IDLE : ST_XFER;
          req[i] <= !last[i];
        end
      end
    end
  end
`ifdef STARVE_WD_EN
  logic [7:0] wait_cnt [4];
  // watchdog: count ungranted REQ cycles, flag at WAIT_LIMIT until the next granted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= 8'd0;
      starve <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept[i]) begin
          wait_cnt[i] <= 8'd0;
        end else if (beat[i]) begin
          wait_cnt[i] <= 8'd0;
          starve[i]   <= 1'b0;
        end else if (st[i] == ST_REQ) begin
          wait_cnt[i] <= (wait_cnt[i] == 8'hff) ? wait_cnt[i] : wait_cnt[i] + 8'd1;
          if ({1'b0, wait_cnt[i]} + 9'd1 >= 9'(WAIT_LIMIT)) starve[i] <= 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_dual_grant_req_agent.sv
// tb_dual_grant_req_agent: directed checks of the four-client request agent.
module tb_dual_grant_req_agent;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_id = 2'd0;
  logic [3:0] cmd_len = 4'd0;
  logic       cmd_ready;
  logic [3:0] grant = 4'd0;
  logic [3:0] req, beat, done;
  logic       err;
  int total = 0;
  int bad = 0;
`ifdef STARVE_WD_EN
  logic [3:0] starve;
`endif

  dual_grant_req_agent #(.WAIT_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_len(cmd_len),
    .cmd_ready(cmd_ready), .grant(grant), .req(req), .beat(beat), .done(done), .err(err)
`ifdef STARVE_WD_EN
    , .starve(starve)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] id, input logic [3:0] l, input logic [3:0] g);
    cmd_valid = v;
    cmd_id    = id;
    cmd_len   = l;
    grant     = g;
    #1;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_req", req, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_err", {3'b0, err}, 4'b0000);
    chk("rst_ready", {3'b0, cmd_ready}, 4'b0001);
    rst_n = 1'b1;
    // id 2, len 3, grant held: four beats then done
    drive(1, 2, 3, 4'b0000);
    chk("a_ready", {3'b0, cmd_ready}, 4'b0001);
    tick();
    drive(0, 2, 0, 4'b0100);
    chk("a_busy_ready", {3'b0, cmd_ready}, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk("a_req", req, 4'b0100);
      chk("a_beat", beat, 4'b0100);
      chk("a_nodone", done, 4'b0000);
      tick();
    end
    drive(0, 2, 0, 4'b0000);
    chk("a_req_end", req, 4'b0000);
    chk("a_done", done, 4'b0100);
    chk("a_noerr", {3'b0, err}, 4'b0000);
    tick();
    chk("a_done_clr", done, 4'b0000);
    // id 0, len 0, granted at once; re-accept on the done cycle
    drive(1, 0, 0, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0001);
    chk("b_req", req, 4'b0001);
    chk("b_beat", beat, 4'b0001);
    tick();
    drive(1, 0, 1, 4'b0000);
    chk("b_done", done, 4'b0001);
    chk("b_req_end", req, 4'b0000);
    chk("b_ready_on_done", {3'b0, cmd_ready}, 4'b0001);
    tick();
    drive(0, 0, 0, 4'b0001);
    chk("b_reaccept", req, 4'b0001);
    chk("b_done_clr", done, 4'b0000);
    tick();
    chk("b_mid", done, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("b_done2", done, 4'b0001);
    // id 1, len 5, grant toggling: done after 11 cycles
    drive(1, 1, 5, 4'b0000);
    tick();
    for (int k = 0; k < 11; k++) begin
      drive(0, 1, 0, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("c_req", req, 4'b0010);
      chk("c_beat", beat, (k % 2 == 0) ? 4'b0010 : 4'b0000);
      chk("c_nodone", done, 4'b0000);
      tick();
    end
    drive(0, 1, 0, 4'b0000);
    chk("c_req_end", req, 4'b0000);
    chk("c_done", done, 4'b0010);
    chk("c_noerr", {3'b0, err}, 4'b0000);
    tick();
    // grant to an idle client is ignored and flagged
    drive(0, 0, 0, 4'b1000);
    chk("d_idle_beat", beat, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("d_idle_err", {3'b0, err}, 4'b0001);
    chk("d_idle_req", req, 4'b0000);
    tick();
    chk("d_err_clr", {3'b0, err}, 4'b0000);
    // activate clients 0, 1, 3 while others are busy
    drive(1, 0, 15, 4'b0000);
    tick();
    drive(1, 1, 15, 4'b0000);
    chk("d_ready1", {3'b0, cmd_ready}, 4'b0001);
    tick();
    drive(1, 3, 15, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0111);
    chk("d_req3", req, 4'b1011);
    chk("d_beat0111", beat, 4'b0011);
    tick();
    drive(0, 0, 0, 4'b1011);
    chk("d_err0111", {3'b0, err}, 4'b0001);
    chk("d_beat1011", beat, 4'b1011);
    tick();
    drive(0, 0, 0, 4'b0011);
    chk("d_err1011", {3'b0, err}, 4'b0001);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("d_err_two", {3'b0, err}, 4'b0000);
    chk("d_still_req", req, 4'b1011);
    // asynchronous reset mid-cycle clears everything
    rst_n = 1'b0;
    #1;
    chk("e_rst_req", req, 4'b0000);
    tick();
    rst_n = 1'b1;
    // id 2 len 3: two beats, then reset with two remaining
    drive(1, 2, 3, 4'b0000);
    chk("e_ready_first", {3'b0, cmd_ready}, 4'b0001);
    tick();
    drive(0, 0, 0, 4'b0100);
    chk("e_req", req, 4'b0100);
    tick();
    tick();
    drive(0, 0, 0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("e_abort_req", req, 4'b0000);
    tick();
    chk("e_abort_done", done, 4'b0000);
    rst_n = 1'b1;
    drive(1, 2, 0, 4'b0000);
    chk("e_ready_rel", {3'b0, cmd_ready}, 4'b0001);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("e_no_done", done, 4'b0000);
    chk("e_new_req", req, 4'b0100);
    drive(0, 0, 0, 4'b0100);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("e_done", done, 4'b0100);
    tick();
    // simultaneous completion on clients 0 and 1
    drive(1, 0, 0, 4'b0000);
    tick();
    drive(1, 1, 0, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0011);
    chk("f_beat", beat, 4'b0011);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("f_done", done, 4'b0011);
    chk("f_req", req, 4'b0000);
    tick();
`ifdef STARVE_WD_EN
    // client 3 starved for WAIT_LIMIT=4 cycles, then cleared by a beat
    drive(1, 3, 1, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk("g_nostarve", starve, 4'b0000);
      tick();
    end
    chk("g_starve", starve, 4'b1000);
    tick();
    chk("g_starve_hold", starve, 4'b1000);
    drive(0, 0, 0, 4'b1000);
    tick();
    chk("g_starve_clr", starve, 4'b0000);
    tick();
    drive(0, 0, 0, 4'b0000);
    chk("g_done", done, 4'b1000);
    tick();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
